// File: rtl/torch_toggle_arbiter.sv
// Round-robin arbiter that shares one redstone line between N requesters and keeps
// line changes under a sliding-window budget. TORCH_ARB_FIXED_PRIORITY_EN selects lowest-index-wins.

module torch_req_lane (
  input  logic req,
  input  logic level,
  input  logic line,
  output logic eff
);
  // A request that would not move the line costs nothing and is ignored.
  assign eff = req && (level != line);
endmodule

module torch_toggle_arbiter #(
  parameter int N           = 4,
  parameter int WINDOW      = 60,
  parameter int MAX_CHANGES = 7,
  parameter int HOLD_CYC    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0]                 req,
  input  logic [N-1:0]                 level,
  output logic [N-1:0]                 gnt,
  output logic                         line_out,
  output logic [$clog2(WINDOW+1)-1:0]  budget,
  output logic                         throttled
);
  localparam int BW = $clog2(WINDOW+1);
  localparam int PW = $clog2(N);
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, THROTTLE} state_t;

  state_t            state, state_nxt;
  logic [WINDOW-1:0] hist;
  logic [HW-1:0]     hold_cnt;
  logic [N-1:0]      eff;
  logic [PW-1:0]     win;
  logic              found, grant, oldest;
  logic [BW-1:0]     budget_nxt;
`ifndef TORCH_ARB_FIXED_PRIORITY_EN
  logic [PW-1:0]     rr_ptr;
`endif

  for (genvar i = 0; i < N; i++) begin : g_lane
    torch_req_lane u_lane (
      .req   (req[i]),
      .level (level[i]),
      .line  (line_out),
      .eff   (eff[i])
    );
  end

  always_comb begin
    logic [PW-1:0] cand;
`ifndef TORCH_ARB_FIXED_PRIORITY_EN
    logic [PW:0]   sum;
`endif
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
`ifdef TORCH_ARB_FIXED_PRIORITY_EN
      cand = PW'(k);
`else
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      cand = sum[PW-1:0];
`endif
      if (!found && eff[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign grant      = (state == IDLE) && found && (budget < BW'(MAX_CHANGES));
  assign oldest     = hist[WINDOW-1];
  assign budget_nxt = budget - BW'(oldest) + BW'(grant);
  assign throttled  = (state == THROTTLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (found) state_nxt = grant ? HOLD : THROTTLE;
      HOLD:     if (hold_cnt == '0) state_nxt = IDLE;
      THROTTLE: if (budget_nxt < BW'(MAX_CHANGES)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hist     <= '0;
      budget   <= '0;
      gnt      <= '0;
      line_out <= 1'b0;
      hold_cnt <= '0;
`ifndef TORCH_ARB_FIXED_PRIORITY_EN
      rr_ptr   <= '0;
`endif
    end else begin
      state  <= state_nxt;
      // Window history: a change entering now leaves the budget WINDOW edges later.
      hist   <= {hist[WINDOW-2:0], grant};
      budget <= budget_nxt;
      gnt    <= grant ? (N'(1) << win) : '0;
      if (grant) begin
        line_out <= level[win];
        hold_cnt <= HW'(HOLD_CYC-1);
`ifndef TORCH_ARB_FIXED_PRIORITY_EN
        rr_ptr   <= (win == PW'(N-1)) ? '0 : win + PW'(1);
`endif
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
    end
  end
endmodule

// File: tb/tb_torch_toggle_arbiter.sv
// Directed bench for torch_toggle_arbiter: expectations are queued per edge and
// checked one edge later against outputs sampled 1 time unit after posedge.

module tb_torch_toggle_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, level, gnt;
  logic       line_out, throttled;
  logic [5:0] budget;

  always #5 clk = ~clk;

  torch_toggle_arbiter #(.N(4), .WINDOW(60), .MAX_CHANGES(7), .HOLD_CYC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .level     (level),
    .gnt       (gnt),
    .line_out  (line_out),
    .budget    (budget),
    .throttled (throttled)
  );

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic       line;
    logic [5:0] budget;
    logic       thr;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push_exp(input string tag, input logic [3:0] g, input logic l,
                          input logic [5:0] b, input logic t);
    exp_t x;
    x.tag = tag; x.gnt = g; x.line = l; x.budget = b; x.thr = t;
    sb.push_back(x);
  endtask

  task automatic tick();
    exp_t x;
    @(posedge clk);
    #1;
    x = sb.pop_front();
    tests++;
    assert (gnt === x.gnt) else begin
      fails++; $error("FAIL %s gnt got %b want %b", x.tag, gnt, x.gnt);
    end
    tests++;
    assert (line_out === x.line) else begin
      fails++; $error("FAIL %s line_out got %b want %b", x.tag, line_out, x.line);
    end
    tests++;
    assert (budget === x.budget) else begin
      fails++; $error("FAIL %s budget got %0d want %0d", x.tag, budget, x.budget);
    end
    tests++;
    assert (throttled === x.thr) else begin
      fails++; $error("FAIL %s throttled got %b want %b", x.tag, throttled, x.thr);
    end
  endtask

  // Changes whose grant edge lies in (e-60, e].
  function automatic logic [5:0] win_cnt(input int e, input int g[$]);
    int c = 0;
    foreach (g[k]) if (g[k] <= e && g[k] > e - 60) c++;
    return 6'(c);
  endfunction

  function automatic logic line_at(input int e, input int g[$]);
    int c = 0;
    foreach (g[k]) if (g[k] <= e) c++;
    return c[0];
  endfunction

  function automatic logic [3:0] gnt_at(input int e, input int g[$], input logic [3:0] o[$]);
    logic [3:0] r = 4'b0000;
    foreach (g[k]) if (g[k] == e) r = o[k];
    return r;
  endfunction

  task automatic do_reset(input logic [3:0] r, input logic [3:0] lv);
    rst = 1'b1; req = r; level = lv;
    push_exp("reset", 4'b0000, 1'b0, 6'd0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic run_edge(input string tag, input int e, input int g[$], input logic [3:0] o[$],
                          input logic [3:0] r, input logic [3:0] lv, input logic thr);
    req = r; level = lv;
    push_exp(tag, gnt_at(e, g, o), line_at(e, g), win_cnt(e, g), thr);
    tick();
  endtask

  initial begin
    int         g_one[$], g_thr[$], g_age[$], g_mid[$];
    logic [3:0] o_one[$], o_thr[$], o_age[$], o_mid[$];

    g_one = '{1};
    o_one = '{4'b0001};
    g_thr = '{1, 4, 7, 10, 13, 16, 19, 62, 65};
    g_mid = '{1, 4, 7, 10, 13, 16, 19};
`ifdef TORCH_ARB_FIXED_PRIORITY_EN
    o_thr = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    o_mid = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    o_thr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    o_mid = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
`endif
    g_age = '{10, 13, 16};
    o_age = '{4'b0010, 4'b0010, 4'b0010};

    // Reset held two cycles with every requester asking for a high line.
    do_reset(4'hF, 4'hF);
    do_reset(4'hF, 4'hF);

    // Single grant, then the line already matches so nothing more is granted.
    for (int e = 1; e <= 6; e++)
      run_edge("single", e, g_one, o_one, 4'b0001, 4'b0001, 1'b0);

    // Round-robin into throttle, release after the first change ages out.
    do_reset(4'hF, 4'hF);
    for (int e = 1; e <= 66; e++)
      run_edge("rr_throttle", e, g_thr, o_thr, 4'hF,
               line_at(e-1, g_thr) ? 4'h0 : 4'hF, (e >= 22 && e <= 60));

    // Three changes then idle; each leaves the window 60 edges later.
    do_reset(4'h0, 4'h0);
    for (int e = 1; e <= 78; e++)
      run_edge("aging", e, g_age, o_age, (e >= 10 && e <= 16) ? 4'b0010 : 4'b0000,
               line_at(e-1, g_age) ? 4'b0000 : 4'b0010, 1'b0);

    // Reset pulse while throttled, then an immediate grant to requester 2.
    do_reset(4'hF, 4'hF);
    for (int e = 1; e <= 29; e++)
      run_edge("mid_pre", e, g_mid, o_mid, 4'hF,
               line_at(e-1, g_mid) ? 4'h0 : 4'hF, (e >= 22));
    do_reset(4'hF, 4'h0);
    req = 4'b0100; level = 4'b0100;
    push_exp("mid_post", 4'b0100, 1'b1, 6'd1, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/torch_toggle_arbiter.md
Name: torch_toggle_arbiter

Overview:
- Shares one driven redstone line, the input of a torch chain, between N requesters.
- Each requester asks for a target level. The arbiter grants one level change per grant, round-robin.
- It enforces a sliding-window change budget so the downstream torch never reaches burnout (8 changes in 60 cycles).
- It sits between control logic and the torch datapath, sequencing all writes to the line.

Parameters:
- N, 4, number of requesters (2..8).
- WINDOW, 60, length of the sliding window in cycles; matches the torch change history depth.
- MAX_CHANGES, 7, maximum line changes allowed inside any WINDOW-cycle span; kept below the torch burnout threshold of 8.
- HOLD_CYC, 2, minimum cycles the line holds after a change before the next grant (>=1).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req  in  N  per-requester request, level-sensitive.
- level  in  N  per-requester desired line level.
- gnt  out  N  one-hot, 1-cycle pulse marking the requester whose change was applied.
- line_out  out  1  driven line into the torch.
- budget  out  $clog2(WINDOW+1)  number of changes in the current window.
- throttled  out  1  high while in THROTTLE state.

Behaviour:
- Reset (rst=1 at a posedge):
  - line_out=0, gnt=0, budget=0, throttled=0.
  - Change history cleared, rr_ptr=0, state=IDLE.
  - Reset dominates everything, including mid-HOLD and mid-THROTTLE.
- Effective request: req[i]=1 and level[i]!=line_out. Non-effective requests are ignored: no gnt, no budget cost.
- History:
  - WINDOW-bit shift register; each cycle it shifts in changed (1 if line_out toggles this edge).
  - budget <= budget - oldest + changed. Both terms can apply on the same edge; the net result may be 0.
  - A change made at edge t drops out of budget at edge t+WINDOW.
- States:
  - IDLE:
    - If an effective request exists and budget<MAX_CHANGES, select winner i by round-robin: search from rr_ptr upward, wrapping mod N.
    - At the next edge: line_out<=level[i], gnt<=one-hot(i), rr_ptr<=(i+1) mod N, hold_cnt<=HOLD_CYC-1, go to HOLD.
    - If an effective request exists and budget>=MAX_CHANGES, go to THROTTLE.
    - Otherwise stay in IDLE.
  - HOLD: gnt=0. If hold_cnt==0, go to IDLE; else decrement hold_cnt. With HOLD_CYC=1, HOLD lasts exactly 1 cycle.
  - THROTTLE: throttled=1, no changes, gnt=0. Return to IDLE on the edge where the computed next budget is below MAX_CHANGES.
- Latency: an effective request sampled in IDLE at edge t produces gnt and line_out at edge t+1. Both are registered and change together.
- At most one line change per cycle; budget never exceeds MAX_CHANGES.
- Requester drops req before its grant: it is not granted. Arbitration is re-evaluated every IDLE cycle.
- Requester changes level while granted: the value sampled at the decision edge is used.
- rr_ptr advances only on a grant.

Optional Feature:
- Macro: TORCH_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest index wins, rr_ptr removed.
- Undefined: round-robin as above.
- Budget, hold and throttle behaviour are identical in both builds.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111, level=4'b1111 -> line_out=0, gnt=0, budget=0, throttled=0.
- Single grant: req=4'b0001, level[0]=1 sampled at edge t -> line_out=1, gnt=4'b0001, budget=1 at t+1; no further gnt at t+2 or t+3 (HOLD); level[0]==line_out afterwards -> no grant.
- Round-robin: all four req=1 with level toggled to !line_out after each grant -> gnt order 0001, 0010, 0100, 1000, 0001, one grant every 3 cycles; with TORCH_ARB_FIXED_PRIORITY_EN -> always 0001.
- Throttle: continuous effective requests -> after the 7th change throttled=1, budget=7, line_out frozen; the next grant occurs only after the first change ages out at edge t0+60, and budget never shows 8.
- Aging: 3 changes at edges 10, 13, 16, then idle -> budget drops to 2, 1, 0 at edges 70, 73, 76.
- Reset mid-THROTTLE: rst pulsed for 1 cycle while throttled=1 -> all outputs cleared next edge; an effective req[2] is then granted one edge after rst deasserts.
